// File: rtl/spi_bridge_pkg.sv
// Shared constants for the Avalon-MM front end of spi_core: register map, STATUS/CONTROL
// bit positions and default FIFO depths.
package spi_bridge_pkg;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_RXDATA  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int unsigned STAT_TX_EMPTY    = 0;
  localparam int unsigned STAT_TX_FULL     = 1;
  localparam int unsigned STAT_RX_EMPTY    = 2;
  localparam int unsigned STAT_RX_FULL     = 3;
  localparam int unsigned STAT_BUSY        = 4;
  localparam int unsigned STAT_TX_DROP     = 5;
  localparam int unsigned STAT_RX_OVERFLOW = 6;
  localparam int unsigned STAT_RX_COUNT    = 8;

  localparam int unsigned CTRL_FLUSH_TX  = 0;
  localparam int unsigned CTRL_FLUSH_RX  = 1;
  localparam int unsigned CTRL_CLR_STICKY = 2;
  localparam int unsigned CTRL_IRQ_EN    = 3;

  localparam int unsigned DEFAULT_TX_DEPTH = 8;
  localparam int unsigned DEFAULT_RX_DEPTH = 8;

endpackage

// File: rtl/spi_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a synchronous flush.
// The head word reads as zero while the FIFO is empty.
module spi_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8,
  localparam int unsigned Aw = $clog2(Depth),
  localparam int unsigned Cw = Aw + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [Cw-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wptr_q, wptr_d;
  logic [Aw-1:0]    rptr_q, rptr_d;
  logic [Cw-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == Cw'(Depth));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // A pop on a full FIFO frees the slot that a same-cycle push then takes.
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + Cw'(push_ok) - Cw'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_avalon_bridge.sv
// Avalon-MM slave front end for spi_core: TX word FIFO feeding the core, RX FIFO capturing
// completed 4-byte packets, plus STATUS/CONTROL registers and a level interrupt.
module spi_avalon_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned TX_DEPTH = DEFAULT_TX_DEPTH,
  parameter int unsigned RX_DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic [31:0] core_data_write,
  output logic        core_go_transfer,
  output logic        core_wr_fifo_empty,
  input  logic        core_wr_fifo_req,
  input  logic [31:0] core_data_read,
  input  logic        core_data_pack_ready,
  output logic        irq
);

  localparam int unsigned TxCw = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RxCw = $clog2(RX_DEPTH) + 1;

  logic            in_flight_q, in_flight_d;
  logic            pack_ready_q;
  logic            tx_drop_q, tx_drop_d;
  logic            rx_ovf_q, rx_ovf_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  logic [31:0]     readdata_q, readdata_d;

  logic            tx_empty, tx_full, rx_empty, rx_full;
  logic [TxCw-1:0] tx_count;
  logic [RxCw-1:0] rx_count;
  logic [31:0]     rx_head;
  logic [31:0]     status;
  logic            tx_push, tx_pop_ok, rx_pop, rx_pop_ok;
  logic            ctrl_wr, flush_tx, flush_rx, clr_sticky;
  logic            rise, busy;
  logic            unused_tx_count;

  assign unused_tx_count = ^tx_count;

  assign ctrl_wr    = avs_write & (avs_address == ADDR_CONTROL);
  assign flush_tx   = ctrl_wr & avs_writedata[CTRL_FLUSH_TX];
  assign flush_rx   = ctrl_wr & avs_writedata[CTRL_FLUSH_RX];
  assign clr_sticky = ctrl_wr & avs_writedata[CTRL_CLR_STICKY];

  assign tx_push   = avs_write & (avs_address == ADDR_TXDATA);
  assign tx_pop_ok = core_wr_fifo_req & ~tx_empty & ~flush_tx;
  assign rx_pop    = avs_read & (avs_address == ADDR_RXDATA);
  assign rx_pop_ok = rx_pop & ~rx_empty & ~flush_rx;
  assign rise      = core_data_pack_ready & ~pack_ready_q;
  assign busy      = in_flight_q | ~tx_empty;

  spi_sync_fifo #(
    .Width (32),
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush_tx),
    .push_i  (tx_push),
    .wdata_i (avs_writedata),
    .pop_i   (core_wr_fifo_req),
    .rdata_o (core_data_write),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  spi_sync_fifo #(
    .Width (32),
    .Depth (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush_rx),
    .push_i  (rise),
    .wdata_i (core_data_read),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign core_go_transfer   = tx_empty;
  assign core_wr_fifo_empty = tx_empty;

  always_comb begin
    status                   = '0;
    status[STAT_TX_EMPTY]    = tx_empty;
    status[STAT_TX_FULL]     = tx_full;
    status[STAT_RX_EMPTY]    = rx_empty;
    status[STAT_RX_FULL]     = rx_full;
    status[STAT_BUSY]        = busy;
    status[STAT_TX_DROP]     = tx_drop_q;
    status[STAT_RX_OVERFLOW] = rx_ovf_q;
    status[STAT_RX_COUNT +: 8] = 8'(rx_count);
  end

  always_comb begin
    readdata_d  = readdata_q;
    in_flight_d = in_flight_q;
    tx_drop_d   = tx_drop_q;
    rx_ovf_d    = rx_ovf_q;
    irq_en_d    = irq_en_q;
    irq_d       = irq_en_q & (~rx_empty | rx_ovf_q);

    if (avs_read) begin
      unique case (avs_address)
        ADDR_TXDATA:  readdata_d = '0;
        ADDR_RXDATA:  readdata_d = rx_head;
        ADDR_STATUS:  readdata_d = status;
        ADDR_CONTROL: readdata_d = {31'b0, irq_en_q};
        default:      readdata_d = '0;
      endcase
    end

    // A new pop outranks the completion of the previous packet in the same cycle.
    if (tx_pop_ok) in_flight_d = 1'b1;
    else if (rise) in_flight_d = 1'b0;

    if (tx_push & tx_full & ~tx_pop_ok & ~flush_tx) tx_drop_d = 1'b1;
    else if (clr_sticky)                            tx_drop_d = 1'b0;

    if (rise & rx_full & ~rx_pop_ok & ~flush_rx) rx_ovf_d = 1'b1;
    else if (clr_sticky)                         rx_ovf_d = 1'b0;

    if (ctrl_wr) irq_en_d = avs_writedata[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight_q  <= 1'b0;
      pack_ready_q <= 1'b0;
      tx_drop_q    <= 1'b0;
      rx_ovf_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      readdata_q   <= '0;
    end else begin
      in_flight_q  <= in_flight_d;
      pack_ready_q <= core_data_pack_ready;
      tx_drop_q    <= tx_drop_d;
      rx_ovf_q     <= rx_ovf_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      readdata_q   <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: doc/spi_avalon_bridge.md
Name: spi_avalon_bridge

Overview:
- Avalon-MM slave front end for spi_core. It buffers 32-bit TX words from the host in a write FIFO and presents the head word to spi_core together with the go/empty handshake.
- When spi_core signals a completed 4-byte packet, the block captures the 32-bit read word into a read FIFO for the host.
- It sits between the Avalon interconnect and spi_core, in the same clock domain.

Parameters:
- TX_DEPTH, 8, write FIFO depth in words (power of two, at least 2)
- RX_DEPTH, 8, read FIFO depth in words (power of two, at least 2)

Ports:
- clk  in  1  system clock, same clock as spi_core
- reset  in  1  asynchronous, active-high reset
- avs_address  in  2  register select
- avs_write  in  1  Avalon write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  Avalon read strobe
- avs_readdata  out  32  read data, valid 1 cycle after avs_read
- core_data_write  out  32  head word of the TX FIFO, drives spi_core data_write_from_avalon
- core_go_transfer  out  1  active-low go; drives spi_core go_transfer
- core_wr_fifo_empty  out  1  TX FIFO empty; drives spi_core wr_fifo_empty
- core_wr_fifo_req  in  1  pop request from spi_core, 1-cycle pulse
- core_data_read  in  32  spi_core data_read_to_avalon
- core_data_pack_ready  in  1  spi_core packet-complete flag
- irq  out  1  level interrupt

Behaviour:
- Register map:
  - 0 TXDATA: write pushes avs_writedata; read returns 0.
  - 1 RXDATA: read pops and returns the head word; read of an empty FIFO returns 0 and does not pop.
  - 2 STATUS (read only): bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full, bit4 busy, bit5 tx_drop, bit6 rx_overflow, bits[15:8] rx_count (zero-extended).
  - 3 CONTROL: bit0 flush_tx, bit1 flush_rx, bit2 clear sticky flags, bit3 irq_en. Only irq_en is stored; flush and clear bits are self-clearing 1-cycle actions. Reading CONTROL returns {31'b0, irq_en}.
- Read latency is 1 cycle; avs_readdata holds its value until the next read.
- TX FIFO is show-ahead: core_data_write equals the head word whenever the FIFO is non-empty, and 0 when empty.
- core_go_transfer = core_wr_fifo_empty = tx_empty, both combinational from the FIFO flags.
- Pop on core_wr_fifo_req = 1. A pop while empty is ignored and does not change in_flight.
- The head word must stay stable from the cycle go goes low until the pop. spi_core latches the word 1 cycle before it pulses core_wr_fifo_req.
- in_flight register:
  - Set on a pop.
  - Cleared on rise = core_data_pack_ready & ~pack_ready_d, where pack_ready_d is a 1-cycle delayed copy.
  - busy = in_flight | ~tx_empty.
- RX capture: on rise, push core_data_read. core_data_pack_ready may stay high for several cycles; only the rising edge captures.
- TX full: a TXDATA write is dropped and sets sticky tx_drop.
- RX full at rise: the word is dropped and sets sticky rx_overflow.
- Simultaneous push and pop on the same FIFO:
  - Both occur; count is unchanged.
  - If full, the pop frees a slot, so the push is accepted.
  - If empty, the push lands and the pop is ignored.
- flush_tx:
  - Empties the TX FIFO in 1 cycle. A concurrent push or pop in that cycle is discarded.
  - in_flight is untouched; the in-flight packet completes and its result is captured.
- flush_rx: empties the RX FIFO; a concurrent capture is discarded.
- Clear sticky flags: clears tx_drop and rx_overflow. A same-cycle set wins over the clear.
- irq = irq_en & (~rx_empty | rx_overflow), registered.
- Reset values:
  - FIFOs empty, in_flight 0, pack_ready_d 0, sticky flags 0, irq_en 0.
  - avs_readdata 0, irq 0, core_data_write 0, core_go_transfer 1, core_wr_fifo_empty 1.
- Reset asserted mid-transfer clears all state. Recovery of spi_core is that block's concern.
- Counters are log2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.

Decomposition:
- Shared package spi_bridge_pkg holds:
  - register address constants ADDR_TXDATA, ADDR_RXDATA, ADDR_STATUS, ADDR_CONTROL
  - STATUS and CONTROL bit-index constants
  - default depths
- One sub-module, spi_sync_fifo: parameterised width and depth, show-ahead, with count/full/empty and a synchronous flush input. It is instantiated twice, for TX and RX.

Test Plan:
- Reset, then read STATUS → 0x00000005; core_go_transfer=1; irq=0.
- Write TXDATA 0xA5C3_0F11 → next cycle core_go_transfer=0 and core_data_write=0xA5C30F11. A core_wr_fifo_req pulse → tx_empty=1, busy=1. core_data_pack_ready held high 3 cycles with core_data_read=0x1234_5678 → exactly one RX word; RXDATA read returns 0x12345678; busy=0.
- Write 9 words with TX_DEPTH=8 and no pops → tx_full=1, tx_drop=1, and pops return words 1..8 in order. Clear sticky flags → tx_drop=0.
- Issue 9 pack_ready rising edges with no host reads → rx_count=8, rx_overflow=1. With irq_en=1, irq=1.
- Issue a TXDATA write and a core_wr_fifo_req in the same cycle with 1 word queued → count stays 1; the new word becomes the head.
- Flush_tx with 3 words queued and 1 in flight → tx_empty=1 next cycle; the in-flight result is still captured. Assert reset mid-packet → all STATUS bits 0 except tx_empty and rx_empty.
